// File: rtl/mips_tb_pkg.sv
// Shared definitions for the MIPS CPU bench monitors.
//   halt_state_t         : halt checker FSM states
//   fail_code_t / FC_*   : verdict codes reported on fail_code
//   RESET_VECTOR_DEFAULT : first fetch address expected after reset
package mips_tb_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        RUN    = 2'd1,
        SETTLE = 2'd2,
        DONE   = 2'd3
    } halt_state_t;

    typedef logic [2:0] fail_code_t;

    localparam fail_code_t FC_NONE           = 3'd0;
    localparam fail_code_t FC_BAD_RESET      = 3'd1;
    localparam fail_code_t FC_MISALIGNED     = 3'd2;
    localparam fail_code_t FC_RW_CONFLICT    = 3'd3;
    localparam fail_code_t FC_V0_MISMATCH    = 3'd4;
    localparam fail_code_t FC_TIMEOUT        = 3'd5;
    localparam fail_code_t FC_EARLY_INACTIVE = 3'd6;
    localparam fail_code_t FC_SETTLE_OVERRUN = 3'd7;

    localparam logic [31:0] RESET_VECTOR_DEFAULT = 32'hBFC0_0000;

endpackage

// File: rtl/mips_sat_counter.sv
// 32-bit saturating up-counter.
//   clk_i   : clock, rising edge
//   rst_ni  : asynchronous active-low reset, count returns to 0
//   clr_i   : synchronous clear, wins over en_i
//   en_i    : increment by one unless already at all-ones
//   count_o : registered count value
module mips_sat_counter (
    input  logic        clk_i,
    input  logic        rst_ni,
    input  logic        clr_i,
    input  logic        en_i,
    output logic [31:0] count_o
);

    logic [31:0] count_q;
    logic [31:0] count_d;

    always_comb begin
        count_d = count_q;
        if (clr_i) begin
            count_d = '0;
        end else if (en_i && (count_q != '1)) begin
            count_d = count_q + 32'd1;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign count_o = count_q;

endmodule

// File: rtl/mips_cpu_halt_checker.sv
// Halt checker for mips_cpu_harvard directed benches. Watches the CPU's
// fetch stream, detects the jump to HALT_ADDR, waits for active to drop and
// checks register_v0, giving a sticky done/pass/fail_code verdict.
//   clk, reset_n       : clock (rising edge), async active-low reset
//   clk_enable         : CPU clock enable; monitor only advances when high
//   active             : CPU running flag
//   instr_address      : CPU fetch address
//   register_v0        : CPU $v0
//   data_read/write    : data-bus strobes
//   done, pass         : sticky verdict flags
//   fail_code          : lowest violated code, 0 when none
//   cycle_count        : enabled cycles spent in RUN/SETTLE
//   fetch_count        : enabled RUN cycles with active high
module mips_cpu_halt_checker
    import mips_tb_pkg::*;
#(
    parameter logic [31:0] RESET_VECTOR = RESET_VECTOR_DEFAULT,
    parameter logic [31:0] HALT_ADDR    = 32'h0000_0000,
    parameter logic [31:0] EXPECTED_V0  = 32'h0000_0001,
    parameter bit          CHECK_V0     = 1'b1,
    parameter logic [31:0] SETTLE_MAX   = 32'd4,
    parameter logic [31:0] MAX_CYCLES   = 32'd1000
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        clk_enable,
    input  logic        active,
    input  logic [31:0] instr_address,
    input  logic [31:0] register_v0,
    input  logic        data_read,
    input  logic        data_write,
    output logic        done,
    output logic        pass,
    output logic [2:0]  fail_code,
    output logic [31:0] cycle_count,
    output logic [31:0] fetch_count
);

    halt_state_t state_q, state_d;
    fail_code_t  code_q, code_d;
    logic        done_q, done_d;
    logic        pass_q, pass_d;

    logic        cyc_inc, fetch_inc, settle_inc, settle_clr;
    logic [31:0] settle_count;
    fail_code_t  viol;
    logic        ok_verdict;

    // The cycle that reaches a verdict is not added to cycle_count, so a
    // timeout reports MAX_CYCLES-1, the value that triggered it.
    always_comb begin
        state_d    = state_q;
        code_d     = code_q;
        done_d     = done_q;
        pass_d     = pass_q;
        cyc_inc    = 1'b0;
        fetch_inc  = 1'b0;
        settle_inc = 1'b0;
        settle_clr = 1'b0;
        viol       = FC_NONE;
        ok_verdict = 1'b0;

        if (clk_enable) begin
            case (state_q)
                IDLE: begin
                    if (instr_address == RESET_VECTOR) begin
                        state_d = RUN;
                    end else begin
                        viol = FC_BAD_RESET;
                    end
                end
                RUN: begin
                    fetch_inc = active;
                    // Ordered lowest code first; a halt fetch only suppresses
                    // the early-inactive check, not the lower codes.
                    if (instr_address[1:0] != 2'b00) begin
                        viol = FC_MISALIGNED;
                    end else if (data_read && data_write) begin
                        viol = FC_RW_CONFLICT;
                    end else if (cycle_count == (MAX_CYCLES - 32'd1)) begin
                        viol = FC_TIMEOUT;
                    end else if (instr_address == HALT_ADDR) begin
                        state_d    = SETTLE;
                        settle_clr = 1'b1;
                        cyc_inc    = 1'b1;
                    end else if (!active) begin
                        viol = FC_EARLY_INACTIVE;
                    end else begin
                        cyc_inc = 1'b1;
                    end
                end
                SETTLE: begin
                    if (data_read && data_write) begin
                        viol = FC_RW_CONFLICT;
                    end else if (!active) begin
                        if (CHECK_V0 && (register_v0 != EXPECTED_V0)) begin
                            viol = FC_V0_MISMATCH;
                        end else begin
                            ok_verdict = 1'b1;
                        end
                    end else if (settle_count == SETTLE_MAX) begin
                        viol = FC_SETTLE_OVERRUN;
                    end else begin
                        settle_inc = 1'b1;
                        cyc_inc    = 1'b1;
                    end
                end
                DONE: begin
                end
            endcase

            if (viol != FC_NONE) begin
                state_d = DONE;
                code_d  = viol;
                done_d  = 1'b1;
            end else if (ok_verdict) begin
                state_d = DONE;
                done_d  = 1'b1;
                pass_d  = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= IDLE;
            code_q  <= FC_NONE;
            done_q  <= 1'b0;
            pass_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            code_q  <= code_d;
            done_q  <= done_d;
            pass_q  <= pass_d;
        end
    end

    mips_sat_counter u_cycle_cnt (
        .clk_i   (clk),
        .rst_ni  (reset_n),
        .clr_i   (1'b0),
        .en_i    (cyc_inc),
        .count_o (cycle_count)
    );

    mips_sat_counter u_fetch_cnt (
        .clk_i   (clk),
        .rst_ni  (reset_n),
        .clr_i   (1'b0),
        .en_i    (fetch_inc),
        .count_o (fetch_count)
    );

    mips_sat_counter u_settle_cnt (
        .clk_i   (clk),
        .rst_ni  (reset_n),
        .clr_i   (settle_clr),
        .en_i    (settle_inc),
        .count_o (settle_count)
    );

    assign done      = done_q;
    assign pass      = pass_q;
    assign fail_code = code_q;

endmodule

// File: tb/tb_mips_cpu_halt_checker.sv
module tb_mips_cpu_halt_checker;

    logic        clk;
    logic        reset_n;
    logic        clk_enable;
    logic        active;
    logic [31:0] instr_address;
    logic [31:0] register_v0;
    logic        data_read;
    logic        data_write;
    logic        done;
    logic        pass;
    logic [2:0]  fail_code;
    logic [31:0] cycle_count;
    logic [31:0] fetch_count;

    int checks = 0;
    int errors = 0;

    mips_cpu_halt_checker #(
        .MAX_CYCLES (32'd16)
    ) dut (
        .clk           (clk),
        .reset_n       (reset_n),
        .clk_enable    (clk_enable),
        .active        (active),
        .instr_address (instr_address),
        .register_v0   (register_v0),
        .data_read     (data_read),
        .data_write    (data_write),
        .done          (done),
        .pass          (pass),
        .fail_code     (fail_code),
        .cycle_count   (cycle_count),
        .fetch_count   (fetch_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    // Inputs change on the falling edge; the rising edge in between consumes
    // them, and the task returns on the next falling edge ready to sample.
    task automatic step(input logic [31:0] addr, input logic act, input logic [31:0] v0,
                        input logic rd, input logic wr, input logic en);
        instr_address = addr;
        active        = act;
        register_v0   = v0;
        data_read     = rd;
        data_write    = wr;
        clk_enable    = en;
        @(negedge clk);
    endtask

    task automatic run(input logic [31:0] addr);
        step(addr, 1'b1, 32'd0, 1'b0, 1'b0, 1'b1);
    endtask

    task automatic do_reset();
        reset_n       = 1'b0;
        clk_enable    = 1'b0;
        active        = 1'b0;
        instr_address = '0;
        register_v0   = '0;
        data_read     = 1'b0;
        data_write    = 1'b0;
        @(negedge clk);
        @(negedge clk);
        reset_n = 1'b1;
    endtask

    task automatic check_verdict(input string tag, input logic d, input logic p, input logic [2:0] c);
        check({tag, "_done"}, {31'd0, done}, {31'd0, d});
        check({tag, "_pass"}, {31'd0, pass}, {31'd0, p});
        check({tag, "_code"}, {29'd0, fail_code}, {29'd0, c});
    endtask

    // Reset vector, four sequential fetches, jr $0 fetch of address 0.
    task automatic program_to_settle();
        run(32'hBFC0_0000);
        run(32'hBFC0_0004);
        run(32'hBFC0_0008);
        run(32'hBFC0_000C);
        run(32'hBFC0_0010);
        run(32'h0000_0000);
    endtask

    initial begin
        do_reset();
        @(negedge clk);

        // Reset state
        check_verdict("reset", 1'b0, 1'b0, 3'd0);
        check("reset_cycles", cycle_count, 32'd0);
        check("reset_fetches", fetch_count, 32'd0);

        // A disabled cycle with a bad address must not trigger the vector check
        step(32'h0000_0123, 1'b1, 32'd0, 1'b0, 1'b0, 1'b0);
        check_verdict("idle_frozen", 1'b0, 1'b0, 3'd0);

        // Passing program: active drops one cycle after the halt fetch, v0=1
        program_to_settle();
        check("settle_not_done", {31'd0, done}, 32'd0);
        step(32'h0000_0000, 1'b0, 32'd1, 1'b0, 1'b0, 1'b1);
        check_verdict("pass_prog", 1'b1, 1'b1, 3'd0);
        check("pass_cycles", cycle_count, 32'd5);
        check("pass_fetches", fetch_count, 32'd5);
        // DONE is terminal: later violations are ignored
        step(32'hBFC0_0006, 1'b1, 32'd0, 1'b1, 1'b1, 1'b1);
        step(32'h0000_0004, 1'b0, 32'd7, 1'b1, 1'b1, 1'b1);
        check_verdict("pass_sticky", 1'b1, 1'b1, 3'd0);
        check("pass_cycles_held", cycle_count, 32'd5);

        // v0 mismatch
        do_reset();
        program_to_settle();
        step(32'h0000_0000, 1'b0, 32'd0, 1'b0, 1'b0, 1'b1);
        check_verdict("v0_bad", 1'b1, 1'b0, 3'd4);

        // Wrong first fetch
        do_reset();
        run(32'hBFC0_0004);
        check_verdict("bad_vector", 1'b1, 1'b0, 3'd1);
        check("bad_vector_cycles", cycle_count, 32'd0);

        // Misaligned fetch and rd/wr conflict together: code 2 wins
        do_reset();
        run(32'hBFC0_0000);
        step(32'hBFC0_0006, 1'b1, 32'd0, 1'b1, 1'b1, 1'b1);
        check_verdict("misalign_prio", 1'b1, 1'b0, 3'd2);

        // Read/write conflict alone
        do_reset();
        run(32'hBFC0_0000);
        run(32'hBFC0_0004);
        step(32'hBFC0_0008, 1'b1, 32'd0, 1'b1, 1'b1, 1'b1);
        check_verdict("rw_conflict", 1'b1, 1'b0, 3'd3);

        // active drops without a halt fetch
        do_reset();
        run(32'hBFC0_0000);
        run(32'hBFC0_0004);
        step(32'hBFC0_0008, 1'b0, 32'd1, 1'b0, 1'b0, 1'b1);
        check_verdict("early_inactive", 1'b1, 1'b0, 3'd6);

        // Settle overrun: four high SETTLE cycles tolerated, fifth fails
        do_reset();
        program_to_settle();
        for (int i = 0; i < 4; i++) run(32'h0000_0000);
        check("overrun_not_yet", {31'd0, done}, 32'd0);
        run(32'h0000_0000);
        check_verdict("settle_overrun", 1'b1, 1'b0, 3'd7);

        // Timeout with MAX_CYCLES=16: verdict on the 16th RUN cycle
        do_reset();
        run(32'hBFC0_0000);
        for (int i = 0; i < 15; i++) run((i % 2 == 0) ? 32'hBFC0_0004 : 32'hBFC0_0008);
        check("timeout_not_yet", {31'd0, done}, 32'd0);
        check("timeout_cycles_pre", cycle_count, 32'd15);
        run(32'hBFC0_0004);
        check_verdict("timeout", 1'b1, 1'b0, 3'd5);
        check("timeout_cycles", cycle_count, 32'd15);
        check("timeout_fetches", fetch_count, 32'd16);

        // Same loop with clk_enable low for 10 clocks: verdict 10 clocks later
        do_reset();
        run(32'hBFC0_0000);
        for (int i = 0; i < 8; i++) run(32'hBFC0_0004);
        for (int i = 0; i < 10; i++) step(32'hBFC0_0004, 1'b1, 32'd0, 1'b0, 1'b0, 1'b0);
        check("stall_frozen_cycles", cycle_count, 32'd8);
        for (int i = 0; i < 7; i++) run(32'hBFC0_0004);
        check("stall_not_yet", {31'd0, done}, 32'd0);
        run(32'hBFC0_0004);
        check_verdict("stall_timeout", 1'b1, 1'b0, 3'd5);

        // Asynchronous reset while in SETTLE, then a clean rerun
        do_reset();
        program_to_settle();
        check("pre_async_cycles", cycle_count, 32'd5);
        #2 reset_n = 1'b0;
        #1;
        check_verdict("async_reset", 1'b0, 1'b0, 3'd0);
        check("async_reset_cycles", cycle_count, 32'd0);
        check("async_reset_fetches", fetch_count, 32'd0);
        @(negedge clk);
        reset_n = 1'b1;
        program_to_settle();
        step(32'h0000_0000, 1'b0, 32'd1, 1'b0, 1'b0, 1'b1);
        check_verdict("rerun_pass", 1'b1, 1'b1, 3'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
